// File: rtl/rs_pulse_driver_pkg.sv
// Shared encodings for the RS latch pulse driver: FSM states, counter width
// and error bit positions.
package rs_drv_pkg;

    localparam int CNT_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PULSE = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_GAP   = 2'd3;

    localparam int ERR_FB       = 0;
    localparam int ERR_CONFLICT = 1;

    // Latch feedback agrees with the commanded target on both rails.
    function automatic logic fb_ok(input logic q, input logic q_b, input logic tgt);
        return (q == tgt) && (q_b == ~tgt);
    endfunction

endpackage

// File: rtl/rs_pulse_driver_if.sv
// Request/pulse/feedback bundle between control logic, the driver and the latch.
interface rs_pulse_driver_if;
    logic       set_req;
    logic       clr_req;
    logic       err_clr;
    logic       ready;
    logic       s;
    logic       r;
    logic       q_fb;
    logic       q_b_fb;
    logic       state_o;
    logic       done;
    logic [1:0] err;

    modport master (
        output set_req, clr_req, err_clr, q_fb, q_b_fb,
        input  ready, s, r, state_o, done, err
    );

    modport slave (
        input  set_req, clr_req, err_clr, q_fb, q_b_fb,
        output ready, s, r, state_o, done, err
    );
endinterface

// File: rtl/rs_pulse_driver_timer.sv
// 8-bit loadable down-counter; shared by the pulse-width and guard-gap phases.
module rs_drv_timer
    import rs_drv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (dec && (value_q != '0)) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/rs_pulse_driver.sv
// Drives the s/r pulse pair of an RS latch from one-cycle set/clear requests,
// verifies the latch feedback afterwards and enforces a guard gap.
module rs_pulse_driver
    import rs_drv_pkg::*;
#(
    parameter int PULSE_W = 4,
    parameter int GAP     = 2
) (
    input  logic            clk,
    input  logic            rst,
    rs_pulse_driver_if.slave bus
);

    localparam logic [CNT_W-1:0] PW_LOAD  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    state_t     state_q, state_d;
    logic       target_q, target_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       done_q, done_d;
    logic       state_o_q, state_o_d;
    logic [1:0] err_q, err_d;
    logic [1:0] err_new;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_dec;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_zero;

    rs_drv_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        state_o_d = state_o_q;
        err_new   = 2'b00;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.set_req && bus.clr_req) begin
                    err_new[ERR_CONFLICT] = 1'b1;
                end else if (bus.set_req || bus.clr_req) begin
                    target_d = bus.set_req;
                    tmr_load = 1'b1;
                    tmr_val  = PW_LOAD;
                    state_d  = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (tmr_zero) state_d = ST_CHECK;
                else          tmr_dec = 1'b1;
            end
            ST_CHECK: begin
                if (!fb_ok(bus.q_fb, bus.q_b_fb, target_q)) err_new[ERR_FB] = 1'b1;
                state_o_d = target_q;
                if (GAP == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_zero) state_d = ST_IDLE;
                else          tmr_dec = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // A newly detected error wins over a clear in the same cycle.
        err_d = (bus.err_clr ? 2'b00 : err_q) | err_new;

        // Outputs are registered from the next state so s and r can never overlap.
        s_d    = (state_d == ST_PULSE) &&  target_d;
        r_d    = (state_d == ST_PULSE) && !target_d;
        done_d = (state_d == ST_CHECK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            target_q  <= 1'b0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            done_q    <= 1'b0;
            state_o_q <= 1'b0;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            s_q       <= s_d;
            r_q       <= r_d;
            done_q    <= done_d;
            state_o_q <= state_o_d;
            err_q     <= err_d;
        end
    end

    assign bus.ready   = (state_q == ST_IDLE);
    assign bus.s       = s_q;
    assign bus.r       = r_q;
    assign bus.done    = done_q;
    assign bus.state_o = state_o_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_rs_pulse_driver.sv
// Bench for rs_pulse_driver: two parameterisations against a timeline model,
// directed scenarios with literal expectations, then random requests.
module tb_rs_pulse_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic err_clr = 1'b0;
    logic fault   = 1'b0;
    logic lat0 = 1'b0;
    logic lat1 = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc   = -1;

    int         pw [2] = '{4, 1};
    int         gp [2] = '{2, 0};
    bit         act[2];
    int         e0 [2];
    bit         tgt[2];
    bit         st [2];
    logic [1:0] er [2];

    always #5 clk = ~clk;

    rs_pulse_driver_if bus0 ();
    rs_pulse_driver_if bus1 ();

    assign bus0.set_req = set_req;
    assign bus0.clr_req = clr_req;
    assign bus0.err_clr = err_clr;
    assign bus1.set_req = set_req;
    assign bus1.clr_req = clr_req;
    assign bus1.err_clr = err_clr;

    always @(bus0.s or bus0.r) begin
        if (bus0.s) lat0 = 1'b1;
        else if (bus0.r) lat0 = 1'b0;
    end
    always @(bus1.s or bus1.r) begin
        if (bus1.s) lat1 = 1'b1;
        else if (bus1.r) lat1 = 1'b0;
    end

    assign bus0.q_fb   = fault ? ~lat0 : lat0;
    assign bus0.q_b_fb = fault ? lat0 : ~lat0;
    assign bus1.q_fb   = fault ? ~lat1 : lat1;
    assign bus1.q_b_fb = fault ? lat1 : ~lat1;

    rs_pulse_driver #(.PULSE_W(4), .GAP(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    rs_pulse_driver #(.PULSE_W(1), .GAP(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            act[k] = 1'b0; e0[k] = 0; tgt[k] = 1'b0; st[k] = 1'b0; er[k] = 2'b00;
        end
    endtask

    // One operation = pulse of pw cycles, one check cycle, gp guard cycles.
    task automatic model_edge(input int k);
        bit         idle;
        logic [1:0] ne;
        idle = !act[k];
        ne   = 2'b00;
        if (act[k] && cyc == e0[k] + pw[k] + 1) begin
            if (fault) ne[0] = 1'b1;
            st[k] = tgt[k];
        end
        if (act[k] && cyc == e0[k] + pw[k] + 1 + gp[k]) act[k] = 1'b0;
        if (idle) begin
            if (set_req && clr_req) ne[1] = 1'b1;
            else if (set_req || clr_req) begin
                act[k] = 1'b1; e0[k] = cyc; tgt[k] = set_req;
            end
        end
        er[k] = (err_clr ? 2'b00 : er[k]) | ne;
    endtask

    task automatic cmp_inst(input int k, input logic rdy, input logic s, input logic r,
                            input logic d, input logic so, input logic [1:0] e);
        bit pul;
        pul = act[k] && cyc >= e0[k] && cyc <= e0[k] + pw[k] - 1;
        chk($sformatf("ready%0d", k), {1'b0, rdy}, {1'b0, !act[k]});
        chk($sformatf("s%0d", k),     {1'b0, s},   {1'b0, pul && tgt[k]});
        chk($sformatf("r%0d", k),     {1'b0, r},   {1'b0, pul && !tgt[k]});
        chk($sformatf("done%0d", k),  {1'b0, d},   {1'b0, act[k] && cyc == e0[k] + pw[k]});
        chk($sformatf("state_o%0d", k), {1'b0, so}, {1'b0, st[k]});
        chk($sformatf("err%0d", k),   e, er[k]);
        chk($sformatf("rs_excl%0d", k), {1'b0, s & r}, 2'b00);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        cmp_inst(0, bus0.ready, bus0.s, bus0.r, bus0.done, bus0.state_o, bus0.err);
        cmp_inst(1, bus1.ready, bus1.s, bus1.r, bus1.done, bus1.state_o, bus1.err);
        $display("[TB] cyc=%0d req=%b%b s0r0=%b%b done0=%b st0=%b err0=%b s1r1=%b%b",
                 cyc, set_req, clr_req, bus0.s, bus0.r, bus0.done, bus0.state_o,
                 bus0.err, bus1.s, bus1.r);
    endtask

    task automatic run_to(input int m);
        while (cyc < m) step();
    endtask

    task automatic pulse_req(input logic sv, input logic cv);
        set_req = sv; clr_req = cv;
        step();
        set_req = 1'b0; clr_req = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {1'b0, bus0.ready}, 2'b01);
        chk("rst_s",     {1'b0, bus0.s}, 2'b00);
        chk("rst_r",     {1'b0, bus0.r}, 2'b00);
        chk("rst_state", {1'b0, bus0.state_o}, 2'b00);
        chk("rst_err",   bus0.err, 2'b00);
        chk("rst_done",  {1'b0, bus0.done}, 2'b00);

        // set sampled at edge 10
        run_to(9);
        pulse_req(1'b1, 1'b0);
        chk("set_s_first", {1'b0, bus0.s}, 2'b01);
        chk("g0_s_single", {1'b0, bus1.s}, 2'b01);
        run_to(13); chk("set_s_last", {1'b0, bus0.s}, 2'b01);
        run_to(14); chk("set_done", {1'b0, bus0.done}, 2'b01);
                    chk("set_s_off", {1'b0, bus0.s}, 2'b00);
        run_to(16); chk("set_gap_busy", {1'b0, bus0.ready}, 2'b00);
        run_to(17); chk("set_ready", {1'b0, bus0.ready}, 2'b01);
                    chk("set_state", {1'b0, bus0.state_o}, 2'b01);

        // clear sampled at edge 18
        pulse_req(1'b0, 1'b1);
        chk("clr_r_first", {1'b0, bus0.r}, 2'b01);
        run_to(21); chk("clr_r_last", {1'b0, bus0.r}, 2'b01);
        run_to(22); chk("clr_done", {1'b0, bus0.done}, 2'b01);
        run_to(23); chk("clr_state", {1'b0, bus0.state_o}, 2'b00);

        // conflicting request
        run_to(25);
        pulse_req(1'b1, 1'b1);
        chk("conf_err", bus0.err, 2'b10);
        chk("conf_ready", {1'b0, bus0.ready}, 2'b01);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("conf_errclr", bus0.err, 2'b00);

        // bad feedback during a set, sampled at the check edge 34
        run_to(28);
        fault = 1'b1;
        pulse_req(1'b1, 1'b0);
        run_to(33); chk("fb_done", {1'b0, bus0.done}, 2'b01);
        run_to(34); chk("fb_err", bus0.err, 2'b01);
        fault = 1'b0;

        // request while busy is ignored; GAP=0 instance returns early
        run_to(38);
        pulse_req(1'b1, 1'b0);
        run_to(39); chk("busy_ready", {1'b0, bus0.ready}, 2'b00);
        pulse_req(1'b1, 1'b0);
        run_to(40); chk("g0_busy", {1'b0, bus1.ready}, 2'b00);
                    chk("fb_sticky", bus0.err, 2'b01);
        run_to(41); chk("g0_ready", {1'b0, bus1.ready}, 2'b01);
        run_to(43); chk("busy_done", {1'b0, bus0.done}, 2'b01);
        run_to(46); chk("busy_no_repeat", {1'b0, bus0.s}, 2'b00);

        // asynchronous reset in the middle of a pulse
        run_to(47);
        pulse_req(1'b1, 1'b0);
        step();
        chk("pre_rst_s", {1'b0, bus0.s}, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk("arst_s",     {1'b0, bus0.s}, 2'b00);
        chk("arst_ready", {1'b0, bus0.ready}, 2'b01);
        chk("arst_state", {1'b0, bus0.state_o}, 2'b00);
        chk("arst_done",  {1'b0, bus0.done}, 2'b00);
        chk("arst_err",   bus0.err, 2'b00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) step();

        for (int i = 0; i < 1500; i++) begin
            set_req = ($urandom_range(0, 7) == 0);
            clr_req = ($urandom_range(0, 7) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            fault   = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
